retire_trace_buffer: RTL and testbench

- RTL capture stage on the core's retire port. Packs each retired instruction (PC, GPR writeback, data-memory op) into a trace record and buffers it in a FIFO.
- Presents records over a valid/ready interface to the lock-step checker. For every popped record, the checker calls model_step and compares against model_get_PC / model_get_GPR / model_dmem_* results.
- Decouples the core's retire rate from the checker's DPI pacing and flags any trace loss.

---
 rtl/retire_trace_pkg.sv | 21 ++
 rtl/simple_processor_pkg.sv | 6 +
 rtl/retire_trace_buffer_trace_fifo.sv | 72 +++++++
 rtl/retire_trace_buffer.sv | 112 +++++++++++
 tb/tb_retire_trace_buffer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/retire_trace_pkg.sv
// Trace record layout for the retire capture stage.
package retire_trace_pkg;

    localparam int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     pc;
        logic                      rd_we;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     rd_data;
        logic                      dmem_op;
        logic                      dmem_we;
        logic [ADDR_WIDTH-1:0]     dmem_addr;
        logic [DATA_WIDTH-1:0]     dmem_data;
    } retire_rec_t;

    localparam int REC_WIDTH = $bits(retire_rec_t);

endpackage

// File: rtl/simple_processor_pkg.sv
// Core-wide widths shared by the simple processor and its trace/debug blocks.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 16;

endpackage

// File: rtl/retire_trace_buffer_trace_fifo.sv
// Generic synchronous FIFO with a wrap-bit on each pointer so full and empty
// can be told apart; head data comes straight from storage and reads zero
// while empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     push_ok_o,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop_i && !empty && !clear_i;
    assign push_ok = push_i && !clear_i && (!full || pop_ok);

    assign push_ok_o = push_ok;
    assign valid_o   = !empty;
    assign count_o   = wr_ptr - rd_ptr;

    // Head record comes from storage; forced to zero so an empty FIFO shows a clean record.
    always_comb begin
        data_o = '0;
        if (!empty) begin
            data_o = mem[rd_ptr[AW-1:0]];
        end
    end

    // Pointer update: clear rewinds both pointers and wins over any push or pop.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; left unreset because pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-port capture stage: normalises each retired instruction into a trace
// record, buffers it for the lock-step checker and flags any dropped record.
module retire_trace_buffer
    import retire_trace_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int DATA_WIDTH     = retire_trace_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = retire_trace_pkg::REG_ADDR_WIDTH,
    parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      ret_valid_i,
    input  logic [ADDR_WIDTH-1:0]     ret_pc_i,
    input  logic                      ret_rd_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] ret_rd_i,
    input  logic [DATA_WIDTH-1:0]     ret_rd_data_i,
    input  logic                      ret_dmem_op_i,
    input  logic                      ret_dmem_we_i,
    input  logic [ADDR_WIDTH-1:0]     ret_dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]     ret_dmem_data_i,
    input  logic                      clear_i,
    output logic                      trc_valid_o,
    input  logic                      trc_ready_i,
    output retire_rec_t               trc_rec_o,
    output logic                      overflow_o,
    output logic [$clog2(DEPTH):0]    occupancy_o,
    output logic [31:0]               retire_count_o
);

    retire_rec_t           push_rec;
    logic [REC_WIDTH-1:0]  head_bits;
    logic                  push_ok;
    logic                  pop_req;
    logic                  drop;

    assign pop_req   = trc_valid_o && trc_ready_i;
    assign drop      = ret_valid_i && !clear_i && !push_ok;
    assign trc_rec_o = head_bits;

    // Build the record, dropping x0 writes and zeroing every field the instruction did not use.
    always_comb begin
        push_rec         = '0;
        push_rec.pc      = ret_pc_i;
        push_rec.rd_we   = ret_rd_we_i && (ret_rd_i != '0);
        if (push_rec.rd_we) begin
            push_rec.rd      = ret_rd_i;
            push_rec.rd_data = ret_rd_data_i;
        end
        push_rec.dmem_op = ret_dmem_op_i;
        if (ret_dmem_op_i) begin
            push_rec.dmem_we   = ret_dmem_we_i;
            push_rec.dmem_addr = ret_dmem_addr_i;
            push_rec.dmem_data = ret_dmem_data_i;
        end
    end

    trace_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .clear_i     (clear_i),
        .push_i      (ret_valid_i),
        .push_data_i (push_rec),
        .pop_i       (pop_req),
        .push_ok_o   (push_ok),
        .valid_o     (trc_valid_o),
        .data_o      (head_bits),
        .count_o     (occupancy_o)
    );

    // Sticky loss flag: set when a retire finds the FIFO full with no pop to make room.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

    // Count of records actually buffered; survives clear and wraps naturally.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            retire_count_o <= '0;
        end else if (push_ok) begin
            retire_count_o <= retire_count_o + 32'd1;
        end
    end

`ifndef SYNTHESIS
    // The retire strobe must be a known value once out of reset.
    always @(posedge clk_i) begin
        if (arst_ni) begin
            a_valid_known : assert (!$isunknown(ret_valid_i))
                else $error("ret_valid_i is X/Z out of reset");
        end
    end

    // A store flag without a memory access means the core's retire fields are inconsistent.
    always @(posedge clk_i) begin
        if (arst_ni && ret_valid_i) begin
            a_store_needs_op : assert (!(ret_dmem_we_i && !ret_dmem_op_i))
                else $error("ret_dmem_we_i set without ret_dmem_op_i");
        end
    end
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: hand-computed records, overflow,
// full-FIFO streaming across wrap, clear and asynchronous reset.
module tb_retire_trace_buffer;
    import retire_trace_pkg::*;

    localparam int DEPTH = 8;

    logic                      clk_i;
    logic                      arst_ni;
    logic                      ret_valid_i;
    logic [ADDR_WIDTH-1:0]     ret_pc_i;
    logic                      ret_rd_we_i;
    logic [REG_ADDR_WIDTH-1:0] ret_rd_i;
    logic [DATA_WIDTH-1:0]     ret_rd_data_i;
    logic                      ret_dmem_op_i;
    logic                      ret_dmem_we_i;
    logic [ADDR_WIDTH-1:0]     ret_dmem_addr_i;
    logic [DATA_WIDTH-1:0]     ret_dmem_data_i;
    logic                      clear_i;
    logic                      trc_valid_o;
    logic                      trc_ready_i;
    retire_rec_t               trc_rec_o;
    logic                      overflow_o;
    logic [$clog2(DEPTH):0]    occupancy_o;
    logic [31:0]               retire_count_o;

    int assert_count = 0;
    int fail_count   = 0;

    retire_rec_t exp_rec;

    retire_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .ret_valid_i     (ret_valid_i),
        .ret_pc_i        (ret_pc_i),
        .ret_rd_we_i     (ret_rd_we_i),
        .ret_rd_i        (ret_rd_i),
        .ret_rd_data_i   (ret_rd_data_i),
        .ret_dmem_op_i   (ret_dmem_op_i),
        .ret_dmem_we_i   (ret_dmem_we_i),
        .ret_dmem_addr_i (ret_dmem_addr_i),
        .ret_dmem_data_i (ret_dmem_data_i),
        .clear_i         (clear_i),
        .trc_valid_o     (trc_valid_o),
        .trc_ready_i     (trc_ready_i),
        .trc_rec_o       (trc_rec_o),
        .overflow_o      (overflow_o),
        .occupancy_o     (occupancy_o),
        .retire_count_o  (retire_count_o)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [ADDR_WIDTH-1:0] pc,
                                  input logic rd_we, input logic [REG_ADDR_WIDTH-1:0] rd,
                                  input logic [DATA_WIDTH-1:0] rd_data,
                                  input logic dmem_op, input logic dmem_we,
                                  input logic [ADDR_WIDTH-1:0] dmem_addr,
                                  input logic [DATA_WIDTH-1:0] dmem_data);
        ret_valid_i     = valid;
        ret_pc_i        = pc;
        ret_rd_we_i     = rd_we;
        ret_rd_i        = rd;
        ret_rd_data_i   = rd_data;
        ret_dmem_op_i   = dmem_op;
        ret_dmem_we_i   = dmem_we;
        ret_dmem_addr_i = dmem_addr;
        ret_dmem_data_i = dmem_data;
    endtask

    task automatic idle_retire();
        apply_stimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance one clock and land 1 ns after the edge, where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arst_ni     = 1'b0;
        clear_i     = 1'b0;
        trc_ready_i = 1'b0;
        idle_retire();

        // Reset state.
        #12;
        check_output("rst_valid", 128'(trc_valid_o), 128'(0));
        check_output("rst_overflow", 128'(overflow_o), 128'(0));
        check_output("rst_occupancy", 128'(occupancy_o), 128'(0));
        check_output("rst_count", 128'(retire_count_o), 128'(0));
        check_output("rst_rec", 128'(trc_rec_o), 128'(0));
        arst_ni = 1'b1;
        tick();

        // Single retire into an empty FIFO with the checker ready.
        $display("[TB] single retire");
        trc_ready_i = 1'b1;
        apply_stimulus(1'b1, 16'h0010, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 16'h1234, 32'h99);
        tick();
        idle_retire();
        exp_rec         = '0;
        exp_rec.pc      = 16'h0010;
        exp_rec.rd_we   = 1'b1;
        exp_rec.rd      = 5'd3;
        exp_rec.rd_data = 32'hDEADBEEF;
        check_output("t1_valid", 128'(trc_valid_o), 128'(1));
        check_output("t1_rec", 128'(trc_rec_o), 128'(exp_rec));
        check_output("t1_occ", 128'(occupancy_o), 128'(1));
        check_output("t1_count", 128'(retire_count_o), 128'(1));
        tick();
        check_output("t1_popped_valid", 128'(trc_valid_o), 128'(0));
        check_output("t1_popped_occ", 128'(occupancy_o), 128'(0));
        check_output("t1_popped_rec", 128'(trc_rec_o), 128'(0));

        // Write to x0 is normalised away, unused dmem fields zeroed.
        $display("[TB] x0 normalisation");
        apply_stimulus(1'b1, 16'h0014, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 16'h4321, 32'h77);
        tick();
        idle_retire();
        exp_rec    = '0;
        exp_rec.pc = 16'h0014;
        check_output("t2_rec", 128'(trc_rec_o), 128'(exp_rec));
        check_output("t2_count", 128'(retire_count_o), 128'(2));
        tick();
        check_output("t2_drained", 128'(occupancy_o), 128'(0));

        // Nine retires with the checker stalled: the ninth is lost.
        $display("[TB] overflow");
        trc_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 16'(i * 4), 1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0, '0, '0);
            tick();
        end
        idle_retire();
        check_output("t3_occ", 128'(occupancy_o), 128'(8));
        check_output("t3_overflow", 128'(overflow_o), 128'(1));
        check_output("t3_count", 128'(retire_count_o), 128'(10));
        trc_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("t3_drain_pc%0d", i), 128'(trc_rec_o.pc), 128'(i * 4));
            tick();
        end
        check_output("t3_empty", 128'(trc_valid_o), 128'(0));
        check_output("t3_overflow_sticky", 128'(overflow_o), 128'(1));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_output("t3_overflow_cleared", 128'(overflow_o), 128'(0));

        // Full FIFO streaming: push and pop every cycle across pointer wrap.
        $display("[TB] full streaming");
        trc_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 16'(16'h0100 + k * 4), 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            tick();
        end
        check_output("t4_full_occ", 128'(occupancy_o), 128'(8));
        trc_ready_i = 1'b1;
        for (int j = 0; j < 20; j++) begin
            apply_stimulus(1'b1, 16'(16'h0100 + (8 + j) * 4), 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            check_output($sformatf("t4_head_pc%0d", j), 128'(trc_rec_o.pc), 128'(16'h0100 + j * 4));
            tick();
            check_output($sformatf("t4_occ%0d", j), 128'(occupancy_o), 128'(8));
            check_output($sformatf("t4_ovf%0d", j), 128'(overflow_o), 128'(0));
        end
        idle_retire();
        check_output("t4_count", 128'(retire_count_o), 128'(38));
        for (int j = 20; j < 28; j++) begin
            check_output($sformatf("t4_tail_pc%0d", j), 128'(trc_rec_o.pc), 128'(16'h0100 + j * 4));
            tick();
        end
        check_output("t4_drained", 128'(occupancy_o), 128'(0));

        // Store record, then clear in the same cycle as another retire.
        $display("[TB] store and clear");
        trc_ready_i = 1'b0;
        apply_stimulus(1'b1, 16'h0200, 1'b0, 5'd7, 32'h1, 1'b1, 1'b1, 16'h0100, 32'h000000AB);
        tick();
        exp_rec           = '0;
        exp_rec.pc        = 16'h0200;
        exp_rec.dmem_op   = 1'b1;
        exp_rec.dmem_we   = 1'b1;
        exp_rec.dmem_addr = 16'h0100;
        exp_rec.dmem_data = 32'h000000AB;
        check_output("t5_store_rec", 128'(trc_rec_o), 128'(exp_rec));
        check_output("t5_store_count", 128'(retire_count_o), 128'(39));
        apply_stimulus(1'b1, 16'h0204, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0, '0, '0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        idle_retire();
        check_output("t5_clear_valid", 128'(trc_valid_o), 128'(0));
        check_output("t5_clear_occ", 128'(occupancy_o), 128'(0));
        check_output("t5_clear_overflow", 128'(overflow_o), 128'(0));
        check_output("t5_clear_count", 128'(retire_count_o), 128'(39));

        // Load with writeback: rd kept, dmem_we stays low.
        apply_stimulus(1'b1, 16'h0208, 1'b1, 5'd5, 32'hCAFE0001, 1'b1, 1'b0, 16'h0120, 32'hCAFE0001);
        tick();
        idle_retire();
        exp_rec           = '0;
        exp_rec.pc        = 16'h0208;
        exp_rec.rd_we     = 1'b1;
        exp_rec.rd        = 5'd5;
        exp_rec.rd_data   = 32'hCAFE0001;
        exp_rec.dmem_op   = 1'b1;
        exp_rec.dmem_addr = 16'h0120;
        exp_rec.dmem_data = 32'hCAFE0001;
        check_output("t5_load_rec", 128'(trc_rec_o), 128'(exp_rec));

        // Three records (load plus two more), then asynchronous reset mid-cycle.
        $display("[TB] async reset");
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 16'(16'h0300 + k * 4), 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            tick();
        end
        idle_retire();
        check_output("t6_pre_occ", 128'(occupancy_o), 128'(3));
        #2;
        arst_ni = 1'b0;
        #1;
        check_output("t6_rst_valid", 128'(trc_valid_o), 128'(0));
        check_output("t6_rst_occ", 128'(occupancy_o), 128'(0));
        check_output("t6_rst_count", 128'(retire_count_o), 128'(0));
        check_output("t6_rst_rec", 128'(trc_rec_o), 128'(0));
        apply_stimulus(1'b1, 16'h0400, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("t6_inrst_occ", 128'(occupancy_o), 128'(0));
        idle_retire();
        #2;
        arst_ni = 1'b1;
        tick();
        check_output("t6_post_valid", 128'(trc_valid_o), 128'(0));
        check_output("t6_post_count", 128'(retire_count_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
